seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_to_bcd.sv | 30 +++
 rtl/seg7_scan_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: glyph encodings,
// the invalid-digit marker and the scan decoder state type.
package seg7_pkg;

    // Segment order is {a,b,c,d,e,f,g} = seg[6:0], active-high.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_STABLE,
        CAPTURED
    } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational glyph-to-BCD lookup; any pattern that is not a legal
// 0-9 glyph maps to BCD_INVALID with the error flag set.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_err
);

    always_comb begin
        o_bcd = BCD_INVALID;
        o_err = 1'b1;
        case (i_seg)
            SEG_0: begin o_bcd = 4'd0; o_err = 1'b0; end
            SEG_1: begin o_bcd = 4'd1; o_err = 1'b0; end
            SEG_2: begin o_bcd = 4'd2; o_err = 1'b0; end
            SEG_3: begin o_bcd = 4'd3; o_err = 1'b0; end
            SEG_4: begin o_bcd = 4'd4; o_err = 1'b0; end
            SEG_5: begin o_bcd = 4'd5; o_err = 1'b0; end
            SEG_6: begin o_bcd = 4'd6; o_err = 1'b0; end
            SEG_7: begin o_bcd = 4'd7; o_err = 1'b0; end
            SEG_8: begin o_bcd = 4'd8; o_err = 1'b0; end
            SEG_9: begin o_bcd = 4'd9; o_err = 1'b0; end
            SEG_BLANK: begin o_bcd = BCD_INVALID; o_err = 1'b1; end
            default: begin o_bcd = BCD_INVALID; o_err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment bus: each digit is captured
// after a stable window, and complete frames are offered on valid/ready.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    overrun
);

    localparam logic [CNT_W-1:0] L_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);

    function automatic logic isOneHot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    logic [6:0]              r_segMeta;
    logic [6:0]              r_segSync;
    logic [NUM_DIGITS-1:0]   r_digMeta;
    logic [NUM_DIGITS-1:0]   r_digSync;

    scan_state_t             r_state;
    scan_state_t             w_stateNext;
    logic [6:0]              r_latSeg;
    logic [6:0]              w_latSegNext;
    logic [NUM_DIGITS-1:0]   r_latDig;
    logic [NUM_DIGITS-1:0]   w_latDigNext;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cntNext;
    logic                    w_capture;
    logic                    w_sampleMatch;
    logic                    w_sampleOneHot;
    logic                    w_evalIdle;

    logic [NUM_DIGITS-1:0]   r_seen;
    logic [NUM_DIGITS-1:0]   w_seenNext;
    logic [4*NUM_DIGITS-1:0] r_workBcd;
    logic [4*NUM_DIGITS-1:0] w_workBcdNext;
    logic [NUM_DIGITS-1:0]   r_workErr;
    logic [NUM_DIGITS-1:0]   w_workErrNext;
    logic                    w_frameDone;

    logic                    r_frameValid;
    logic                    w_frameValidNext;
    logic [4*NUM_DIGITS-1:0] r_bcdOut;
    logic [4*NUM_DIGITS-1:0] w_bcdOutNext;
    logic [NUM_DIGITS-1:0]   r_digitErr;
    logic [NUM_DIGITS-1:0]   w_digitErrNext;
    logic                    r_overrun;
    logic                    w_overrunNext;

    logic [3:0]              w_decBcd;
    logic                    w_decErr;

    // The display bus is asynchronous; both halves use identical 2-flop
    // synchronizers so a simultaneous seg/enable change stays aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segMeta <= '0;
            r_segSync <= '0;
            r_digMeta <= '0;
            r_digSync <= '0;
        end else begin
            r_segMeta <= seg_in;
            r_segSync <= r_segMeta;
            r_digMeta <= dig_en;
            r_digSync <= r_digMeta;
        end
    end

    seg7_to_bcd u_seg7_to_bcd (
        .i_seg (r_latSeg),
        .o_bcd (w_decBcd),
        .o_err (w_decErr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_latSeg <= '0;
            r_latDig <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_latSeg <= w_latSegNext;
            r_latDig <= w_latDigNext;
            r_cnt    <= w_cntNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_latSegNext   = r_latSeg;
        w_latDigNext   = r_latDig;
        w_cntNext      = r_cnt;
        w_capture      = 1'b0;
        w_evalIdle     = 1'b0;
        w_sampleMatch  = (r_segSync == r_latSeg) && (r_digSync == r_latDig);
        w_sampleOneHot = isOneHot(r_digSync);

        case (r_state)
            WAIT_STABLE: begin
                if (w_sampleMatch) begin
                    w_cntNext = r_cnt + L_ONE;
                    if (r_cnt + L_ONE == L_STABLE) begin
                        w_capture   = 1'b1;
                        w_stateNext = CAPTURED;
                    end
                end else begin
                    w_evalIdle = 1'b1;
                end
            end
            // Holding here until the sample changes limits each enable
            // period to a single capture.
            CAPTURED: begin
                if (!w_sampleMatch) begin
                    w_evalIdle = 1'b1;
                end
            end
            default: begin
                w_evalIdle = 1'b1;
            end
        endcase

        if (w_evalIdle) begin
            if (w_sampleOneHot) begin
                w_latSegNext = r_segSync;
                w_latDigNext = r_digSync;
                w_cntNext    = L_ONE;
                w_stateNext  = WAIT_STABLE;
            end else begin
                w_cntNext   = '0;
                w_stateNext = IDLE;
            end
        end
    end

    always_comb begin
        w_frameDone      = &r_seen;
        w_seenNext       = w_frameDone ? '0 : r_seen;
        w_workBcdNext    = r_workBcd;
        w_workErrNext    = r_workErr;
        w_frameValidNext = r_frameValid;
        w_bcdOutNext     = r_bcdOut;
        w_digitErrNext   = r_digitErr;
        w_overrunNext    = r_overrun;

        if (w_capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_latDig[i]) begin
                    w_seenNext[i]          = 1'b1;
                    w_workBcdNext[4*i +: 4] = w_decBcd;
                    w_workErrNext[i]       = w_decErr;
                end
            end
        end

        // A completed frame only replaces the outputs if the previous one
        // is gone or leaving this cycle; otherwise it is dropped.
        if (w_frameDone) begin
            if (r_frameValid && !frame_ready) begin
                w_overrunNext = 1'b1;
            end else begin
                w_frameValidNext = 1'b1;
                w_bcdOutNext     = r_workBcd;
                w_digitErrNext   = r_workErr;
            end
        end else if (r_frameValid && frame_ready) begin
            w_frameValidNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen       <= '0;
            r_workBcd    <= '0;
            r_workErr    <= '0;
            r_frameValid <= 1'b0;
            r_bcdOut     <= '0;
            r_digitErr   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_seen       <= w_seenNext;
            r_workBcd    <= w_workBcdNext;
            r_workErr    <= w_workErrNext;
            r_frameValid <= w_frameValidNext;
            r_bcdOut     <= w_bcdOutNext;
            r_digitErr   <= w_digitErrNext;
            r_overrun    <= w_overrunNext;
        end
    end

    assign frame_valid = r_frameValid;
    assign bcd_out     = r_bcdOut;
    assign digit_err   = r_digitErr;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives scan sequences on the display
// bus and compares recovered frames against hand-computed values.
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    seg_in;
    logic [ND-1:0] dig_en;
    logic          frame_ready;
    logic          frame_valid;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] digit_err;
    logic          overrun;

    int checkCount  = 0;
    int passCount   = 0;
    int acceptCount = 0;
    int validRise   = 0;
    logic [15:0] lastBcd = '0;
    logic [3:0]  lastErr = '0;
    logic        prevValid = 1'b0;
    int          acceptBase;
    int          riseBase;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .bcd_out     (bcd_out),
        .digit_err   (digit_err),
        .overrun     (overrun)
    );

    // Record every frame the consumer actually accepts.
    always @(posedge clk) begin
        if (frame_valid && frame_ready) begin
            acceptCount++;
            lastBcd = bcd_out;
            lastErr = digit_err;
        end
    end

    always @(negedge clk) begin
        if (frame_valid && !prevValid) validRise++;
        prevValid = frame_valid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [6:0] seg, input logic [ND-1:0] dig,
                                 input int cycles);
        seg_in = seg;
        dig_en = dig;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic scanFrame(input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3);
        applyStimulus(g0, 4'b0001, 10);
        applyStimulus(g1, 4'b0010, 10);
        applyStimulus(g2, 4'b0100, 10);
        applyStimulus(g3, 4'b1000, 10);
        applyStimulus(SEG_BLANK, 4'b0000, 6);
    endtask

    initial begin
        rst_n       = 1'b0;
        seg_in      = SEG_BLANK;
        dig_en      = '0;
        frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(frame_valid), 32'h0);
        checkOutput("reset_bcd", 32'(bcd_out), 32'h0);
        checkOutput("reset_err", 32'(digit_err), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] clean scan");
        scanFrame(SEG_9, SEG_1, SEG_2, SEG_3);
        checkOutput("clean_accepts", 32'(acceptCount), 32'd1);
        checkOutput("clean_pulses", 32'(validRise), 32'd1);
        checkOutput("clean_bcd", 32'(lastBcd), 32'h3219);
        checkOutput("clean_err", 32'(lastErr), 32'h0);
        checkOutput("clean_valid_low", 32'(frame_valid), 32'h0);
        checkOutput("clean_bcd_held", 32'(bcd_out), 32'h3219);

        $display("[TB] glitch rejection");
        applyStimulus(SEG_8, 4'b0001, 3);
        applyStimulus(SEG_5, 4'b0001, 10);
        applyStimulus(SEG_1, 4'b0010, 10);
        applyStimulus(SEG_2, 4'b0100, 10);
        applyStimulus(SEG_3, 4'b1000, 10);
        applyStimulus(SEG_BLANK, 4'b0000, 6);
        checkOutput("glitch_accepts", 32'(acceptCount), 32'd2);
        checkOutput("glitch_bcd", 32'(lastBcd), 32'h3215);

        $display("[TB] illegal pattern");
        scanFrame(SEG_0, SEG_1, 7'h01, SEG_3);
        checkOutput("illegal_accepts", 32'(acceptCount), 32'd3);
        checkOutput("illegal_bcd", 32'(lastBcd), 32'h3F10);
        checkOutput("illegal_err", 32'(lastErr), 32'b0100);

        $display("[TB] blanking and multi-hot");
        acceptBase = acceptCount;
        riseBase   = validRise;
        applyStimulus(SEG_0, 4'b0000, 20);
        applyStimulus(SEG_0, 4'b0011, 20);
        applyStimulus(SEG_4, 4'b0100, 10);
        applyStimulus(SEG_5, 4'b1000, 10);
        applyStimulus(SEG_BLANK, 4'b0000, 6);
        checkOutput("multihot_no_frame", 32'(acceptCount), 32'(acceptBase));
        checkOutput("multihot_no_pulse", 32'(validRise), 32'(riseBase));
        checkOutput("multihot_valid", 32'(frame_valid), 32'h0);
        applyStimulus(SEG_6, 4'b0001, 10);
        applyStimulus(SEG_7, 4'b0010, 10);
        applyStimulus(SEG_BLANK, 4'b0000, 6);
        checkOutput("multihot_complete", 32'(acceptCount), 32'(acceptBase + 1));
        checkOutput("multihot_bcd", 32'(lastBcd), 32'h5476);

        $display("[TB] backpressure");
        acceptBase  = acceptCount;
        frame_ready = 1'b0;
        scanFrame(SEG_8, SEG_8, SEG_8, SEG_8);
        checkOutput("bp_first_valid", 32'(frame_valid), 32'h1);
        checkOutput("bp_first_bcd", 32'(bcd_out), 32'h8888);
        checkOutput("bp_first_overrun", 32'(overrun), 32'h0);
        scanFrame(SEG_1, SEG_1, SEG_1, SEG_1);
        checkOutput("bp_held_valid", 32'(frame_valid), 32'h1);
        checkOutput("bp_held_bcd", 32'(bcd_out), 32'h8888);
        checkOutput("bp_overrun", 32'(overrun), 32'h1);
        frame_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(frame_valid), 32'h0);
        checkOutput("bp_release_accepts", 32'(acceptCount), 32'(acceptBase + 1));
        checkOutput("bp_release_bcd", 32'(lastBcd), 32'h8888);

        $display("[TB] reset mid-scan");
        applyStimulus(SEG_0, 4'b0001, 10);
        applyStimulus(SEG_1, 4'b0010, 10);
        applyStimulus(SEG_4, 4'b0100, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(frame_valid), 32'h0);
        checkOutput("midrst_bcd", 32'(bcd_out), 32'h0);
        checkOutput("midrst_err", 32'(digit_err), 32'h0);
        checkOutput("midrst_overrun", 32'(overrun), 32'h0);
        applyStimulus(SEG_BLANK, 4'b0000, 3);
        rst_n = 1'b1;
        acceptBase = acceptCount;
        applyStimulus(SEG_7, 4'b0100, 10);
        applyStimulus(SEG_9, 4'b1000, 10);
        applyStimulus(SEG_BLANK, 4'b0000, 6);
        checkOutput("postrst_partial", 32'(acceptCount), 32'(acceptBase));
        applyStimulus(SEG_5, 4'b0001, 10);
        applyStimulus(SEG_6, 4'b0010, 10);
        applyStimulus(SEG_BLANK, 4'b0000, 6);
        checkOutput("postrst_accepts", 32'(acceptCount), 32'(acceptBase + 1));
        checkOutput("postrst_bcd", 32'(lastBcd), 32'h9765);
        checkOutput("postrst_err", 32'(lastErr), 32'h0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
